// File: rtl/axi_rd_arbiter.sv
// Round-robin NUM_M:1 arbiter sharing one AXI4 read port (AR/R) between masters, one burst at a time.
// Optional: define AXI_RD_ARB_LEN_CHECK_EN to build the sticky burst-length checker behind LEN_ERR.
module axi_rd_arbiter #(
  parameter int NUM_M      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int GW         = $clog2(NUM_M)
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [NUM_M*ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [NUM_M*8-1:0]          S_ARLEN,
  input  logic [NUM_M*3-1:0]          S_ARSIZE,
  input  logic [NUM_M*2-1:0]          S_ARBURST,
  input  logic [NUM_M-1:0]            S_ARVALID,
  output logic [NUM_M-1:0]            S_ARREADY,
  output logic [DATA_WIDTH-1:0]       S_RDATA,
  output logic [1:0]                  S_RRESP,
  output logic                        S_RLAST,
  output logic [NUM_M-1:0]            S_RVALID,
  input  logic [NUM_M-1:0]            S_RREADY,
  output logic [ADDR_WIDTH-1:0]       M_ARADDR,
  output logic [7:0]                  M_ARLEN,
  output logic [2:0]                  M_ARSIZE,
  output logic [1:0]                  M_ARBURST,
  output logic                        M_ARVALID,
  input  logic                        M_ARREADY,
  input  logic [DATA_WIDTH-1:0]       M_RDATA,
  input  logic [1:0]                  M_RRESP,
  input  logic                        M_RLAST,
  input  logic                        M_RVALID,
  output logic                        M_RREADY,
  output logic [GW-1:0]               GRANT,
  output logic                        BUSY,
  output logic                        LEN_ERR
);

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  localparam logic [GW:0]   NUM_M_W = (GW+1)'(NUM_M);
  localparam logic [GW-1:0] LAST_M  = GW'(NUM_M - 1);

  logic [1:0]    state_reg, state_next;
  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] pick;
  logic [GW:0]   cand;
  logic          in_addr, in_data, ar_hs, r_hs;

  logic [ADDR_WIDTH-1:0] araddr_arr  [NUM_M];
  logic [7:0]            arlen_arr   [NUM_M];
  logic [2:0]            arsize_arr  [NUM_M];
  logic [1:0]            arburst_arr [NUM_M];

  assign in_addr = (state_reg == ARB_ADDR);
  assign in_data = (state_reg == ARB_DATA);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_master
      assign araddr_arr[gi]  = S_ARADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign arlen_arr[gi]   = S_ARLEN[gi*8 +: 8];
      assign arsize_arr[gi]  = S_ARSIZE[gi*3 +: 3];
      assign arburst_arr[gi] = S_ARBURST[gi*2 +: 2];
      assign S_ARREADY[gi]   = in_addr && (grant_reg == GW'(gi)) && M_ARREADY;
      assign S_RVALID[gi]    = in_data && (grant_reg == GW'(gi)) && M_RVALID;
    end
  endgenerate

  assign M_ARADDR  = araddr_arr[grant_reg];
  assign M_ARLEN   = arlen_arr[grant_reg];
  assign M_ARSIZE  = arsize_arr[grant_reg];
  assign M_ARBURST = arburst_arr[grant_reg];
  assign M_ARVALID = in_addr && S_ARVALID[grant_reg];
  assign M_RREADY  = in_data && S_RREADY[grant_reg];

  assign S_RDATA = M_RDATA;
  assign S_RRESP = M_RRESP;
  assign S_RLAST = M_RLAST;

  assign ar_hs = M_ARVALID && M_ARREADY;
  assign r_hs  = M_RVALID && M_RREADY;

  assign GRANT = grant_reg;
  assign BUSY  = (state_reg != ARB_IDLE);

  // Walk candidates from the far end back to rr_ptr so the nearest requester wins last.
  always_comb begin
    pick = rr_ptr_reg;
    cand = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_reg} + (GW+1)'(k);
      if (cand >= NUM_M_W) cand = cand - NUM_M_W;
      if (S_ARVALID[cand[GW-1:0]]) pick = cand[GW-1:0];
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (|S_ARVALID) begin
          grant_next = pick;
          state_next = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (ar_hs) state_next = ARB_DATA;
      end
      ARB_DATA: begin
        if (r_hs && M_RLAST) begin
          state_next  = ARB_IDLE;
          rr_ptr_next = (grant_reg == LAST_M) ? '0 : grant_reg + GW'(1);
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg  <= ARB_IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
    end
  end

`ifdef AXI_RD_ARB_LEN_CHECK_EN
  logic [8:0] beats_exp_reg, beat_cnt_reg, beat_now;
  logic       len_err_reg;

  assign beat_now = beat_cnt_reg + 9'd1;

  // Release always follows RLAST; the checker only observes and never changes arbitration.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      beats_exp_reg <= '0;
      beat_cnt_reg  <= '0;
      len_err_reg   <= 1'b0;
    end else begin
      if (in_addr && ar_hs) begin
        beats_exp_reg <= {1'b0, M_ARLEN} + 9'd1;
        beat_cnt_reg  <= '0;
      end
      if (in_data && r_hs) begin
        beat_cnt_reg <= M_RLAST ? 9'd0 : beat_now;
        if ((M_RLAST && (beat_now != beats_exp_reg)) ||
            (!M_RLAST && (beat_now >= beats_exp_reg)))
          len_err_reg <= 1'b1;
      end
    end
  end

  assign LEN_ERR = len_err_reg;
`else
  assign LEN_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: the bench plays masters and slave, predicting grants
// with a modulo round-robin model and checking every routed AR/R signal cycle by cycle.
module tb_axi_rd_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 1;
`ifdef AXI_RD_ARB_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [NM*AW-1:0] S_ARADDR;
  logic [NM*8-1:0]  S_ARLEN;
  logic [NM*3-1:0]  S_ARSIZE;
  logic [NM*2-1:0]  S_ARBURST;
  logic [NM-1:0]    S_ARVALID;
  logic [NM-1:0]    S_ARREADY;
  logic [DW-1:0]    S_RDATA;
  logic [1:0]       S_RRESP;
  logic             S_RLAST;
  logic [NM-1:0]    S_RVALID;
  logic [NM-1:0]    S_RREADY;
  logic [AW-1:0]    M_ARADDR;
  logic [7:0]       M_ARLEN;
  logic [2:0]       M_ARSIZE;
  logic [1:0]       M_ARBURST;
  logic             M_ARVALID;
  logic             M_ARREADY;
  logic [DW-1:0]    M_RDATA;
  logic [1:0]       M_RRESP;
  logic             M_RLAST;
  logic             M_RVALID;
  logic             M_RREADY;
  logic [GW-1:0]    GRANT;
  logic             BUSY;
  logic             LEN_ERR;

  always #5 ACLK = ~ACLK;

  axi_rd_arbiter #(.NUM_M(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .GRANT(GRANT), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rr_model;
  bit len_err_model;
  bit rand_rdy;
  logic [AW-1:0] req_addr  [NM];
  int            req_len   [NM];
  logic [2:0]    req_size  [NM];
  logic [1:0]    req_burst [NM];

  // Round-robin rule: first requester at or after ptr, wrapping modulo NM.
  function automatic int model_pick(input logic [NM-1:0] mask, input int ptr);
    for (int k = 0; k < NM; k++)
      if (mask[(ptr + k) % NM]) return (ptr + k) % NM;
    return 0;
  endfunction

  task automatic set_req(input int m, input logic [AW-1:0] a, input int len, input logic [1:0] burst);
    req_addr[m]  = a;
    req_len[m]   = len;
    req_size[m]  = 3'($urandom_range(0, 2));
    req_burst[m] = burst;
    S_ARADDR[m*AW +: AW] = a;
    S_ARLEN[m*8 +: 8]    = 8'(len);
    S_ARSIZE[m*3 +: 3]   = req_size[m];
    S_ARBURST[m*2 +: 2]  = burst;
    S_ARVALID[m]         = 1'b1;
  endtask

  // One full transaction from arbitration to release; call with the DUT idle, away from the edge.
  task automatic serve(input int early_last, input int stall_beat, input int stall_len);
    int g, last_beat, beats, stall_left;
    bit ar_done, done, acc;
    logic [NM-1:0] exp_vec;
    g = model_pick(S_ARVALID, rr_model);
    last_beat = (early_last >= 0) ? early_last : req_len[g];
    stall_left = stall_len;

    @(posedge ACLK); #1;
    n_cmp++;
    if (GRANT !== GW'(g) || BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL arb_grant: got GRANT=%0d BUSY=%0b, want GRANT=%0d BUSY=1", GRANT, BUSY, g);
    end

    ar_done = 1'b0;
    for (int cyc = 0; cyc < 16 && !ar_done; cyc++) begin
      M_ARREADY = (cyc >= 3) || ($urandom_range(0, 1) == 1);
      #1;
      exp_vec = '0;
      exp_vec[g] = M_ARREADY;
      n_cmp++;
      if (M_ARVALID !== 1'b1 || M_ARADDR !== req_addr[g] || M_ARLEN !== 8'(req_len[g]) ||
          M_ARSIZE !== req_size[g] || M_ARBURST !== req_burst[g] || S_ARREADY !== exp_vec ||
          M_RREADY !== 1'b0 || S_RVALID !== '0) begin
        n_bad++;
        $display("FAIL ar_route: got v=%0b a=%h len=%0d sz=%0d bu=%0d ardy=%b rrdy=%0b rv=%b, want v=1 a=%h len=%0d sz=%0d bu=%0d ardy=%b rrdy=0 rv=0",
                 M_ARVALID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, S_ARREADY, M_RREADY, S_RVALID,
                 req_addr[g], req_len[g], req_size[g], req_burst[g], exp_vec);
      end
      ar_done = M_ARREADY;
      @(posedge ACLK); #1;
    end
    M_ARREADY = 1'b0;
    S_ARVALID[g] = 1'b0;

    beats = 0;
    done = 1'b0;
    acc = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (acc) begin
        M_RVALID = (stall_len > 0) || ($urandom_range(0, 3) != 0);
        M_RDATA  = $urandom;
        M_RRESP  = 2'($urandom_range(0, 3));
        M_RLAST  = (beats == last_beat);
      end
      S_RREADY = NM'($urandom);
      if (stall_left > 0 && beats == stall_beat) begin
        S_RREADY[g] = 1'b0;
        stall_left--;
      end else if (!rand_rdy) begin
        S_RREADY[g] = 1'b1;
      end
      #1;
      exp_vec = '0;
      exp_vec[g] = M_RVALID;
      n_cmp++;
      if (S_RVALID !== exp_vec || M_RREADY !== S_RREADY[g] || S_RDATA !== M_RDATA ||
          S_RRESP !== M_RRESP || S_RLAST !== M_RLAST || S_ARREADY !== '0 ||
          M_ARVALID !== 1'b0 || BUSY !== 1'b1) begin
        n_bad++;
        $display("FAIL r_route: got rv=%b rrdy=%0b d=%h resp=%0d last=%0b ardy=%b arv=%0b busy=%0b, want rv=%b rrdy=%0b d=%h resp=%0d last=%0b ardy=0 arv=0 busy=1",
                 S_RVALID, M_RREADY, S_RDATA, S_RRESP, S_RLAST, S_ARREADY, M_ARVALID, BUSY,
                 exp_vec, S_RREADY[g], M_RDATA, M_RRESP, M_RLAST);
      end
      acc = !M_RVALID || S_RREADY[g];
      if (M_RVALID && S_RREADY[g]) begin
        beats++;
        done = M_RLAST;
      end
      @(posedge ACLK); #1;
    end
    M_RVALID = 1'b0;
    M_RLAST  = 1'b0;
    S_RREADY = '0;
    #1;
    n_cmp++;
    if (!done || BUSY !== 1'b0 || M_RREADY !== 1'b0 || S_RVALID !== '0 || M_ARVALID !== 1'b0) begin
      n_bad++;
      $display("FAIL release: got done=%0b beats=%0d busy=%0b rrdy=%0b rv=%b arv=%0b, want done=1 beats=%0d busy=0 rrdy=0 rv=0 arv=0",
               done, beats, BUSY, M_RREADY, S_RVALID, M_ARVALID, last_beat + 1);
    end
    if (LEN_CHK && last_beat != req_len[g]) len_err_model = 1'b1;
    n_cmp++;
    if (LEN_ERR !== len_err_model) begin
      n_bad++;
      $display("FAIL len_err: got %0b, want %0b", LEN_ERR, len_err_model);
    end
    rr_model = (g + 1) % NM;
    $display("txn: master %0d addr %h arlen %0d beats %0d len_err %0b", g, req_addr[g], req_len[g], beats, LEN_ERR);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    S_ARVALID = '1;
    M_ARREADY = 1'b1;
    M_RVALID = 1'b1;
    S_RREADY = '1;
    repeat (2) @(posedge ACLK);
    #1;
    n_cmp++;
    if (BUSY !== 1'b0 || GRANT !== '0 || LEN_ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_regs: got busy=%0b grant=%0d len_err=%0b, want 0 0 0", BUSY, GRANT, LEN_ERR);
    end
    n_cmp++;
    if (M_ARVALID !== 1'b0 || M_RREADY !== 1'b0 || S_ARREADY !== '0 || S_RVALID !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got arv=%0b rrdy=%0b ardy=%b rv=%b, want all 0", M_ARVALID, M_RREADY, S_ARREADY, S_RVALID);
    end
    S_ARVALID = '0;
    M_ARREADY = 1'b0;
    ARESET = 1'b0;
    rr_model = 0;
    len_err_model = 1'b0;
    @(posedge ACLK); #1;
    n_cmp++;
    if (BUSY !== 1'b0 || M_RREADY !== 1'b0 || S_RVALID !== '0) begin
      n_bad++;
      $display("FAIL idle_stray_r: got busy=%0b rrdy=%0b rv=%b, want 0 0 0", BUSY, M_RREADY, S_RVALID);
    end
    M_RVALID = 1'b0;
    S_RREADY = '0;
  endtask

  task automatic test_single();
    set_req(0, 32'h10, 3, 2'b01);
    serve(-1, -1, 0);
  endtask

  task automatic test_contention();
    test_reset();
    set_req(0, $urandom, $urandom_range(0, 3), 2'b01);
    set_req(1, $urandom, $urandom_range(0, 3), 2'b01);
    serve(-1, -1, 0);
    serve(-1, -1, 0);
  endtask

  task automatic test_fairness();
    for (int t = 0; t < 6; t++) begin
      for (int m = 0; m < NM; m++)
        if (!S_ARVALID[m]) set_req(m, $urandom, 0, 2'b01);
      serve(-1, -1, 0);
    end
  endtask

  task automatic test_backpressure();
    if (S_ARVALID != '0) serve(-1, -1, 0);
    set_req(1, $urandom, 4, 2'b01);
    serve(-1, 2, 3);
  endtask

  task automatic test_random();
    rand_rdy = 1'b1;
    for (int t = 0; t < 24; t++) begin
      for (int m = 0; m < NM; m++)
        if (!S_ARVALID[m] && $urandom_range(0, 1) == 1)
          set_req(m, $urandom, $urandom_range(0, 7), 2'($urandom_range(0, 2)));
      if (S_ARVALID == '0)
        set_req(int'($urandom_range(0, NM - 1)), $urandom, $urandom_range(0, 7), 2'b01);
      serve(-1, -1, 0);
    end
    while (S_ARVALID != '0) serve(-1, -1, 0);
    rand_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'h200, 3, 2'b01);
    @(posedge ACLK); #1;
    M_ARREADY = 1'b1;
    @(posedge ACLK); #1;
    M_ARREADY = 1'b0;
    S_ARVALID[0] = 1'b0;
    M_RVALID = 1'b1;
    M_RLAST = 1'b0;
    M_RDATA = $urandom;
    S_RREADY = '1;
    repeat (2) @(posedge ACLK);
    #3;
    ARESET = 1'b1;
    #1;
    n_cmp++;
    if (BUSY !== 1'b0 || GRANT !== '0 || S_RVALID !== '0 || M_RREADY !== 1'b0 ||
        M_ARVALID !== 1'b0 || S_ARREADY !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%0b grant=%0d rv=%b rrdy=%0b arv=%0b ardy=%b, want all 0",
               BUSY, GRANT, S_RVALID, M_RREADY, M_ARVALID, S_ARREADY);
    end
    @(posedge ACLK); #2;
    ARESET = 1'b0;
    rr_model = 0;
    len_err_model = 1'b0;
    M_RVALID = 1'b0;
    S_RREADY = '0;
    set_req(1, $urandom, $urandom_range(0, 3), 2'b01);
    serve(-1, -1, 0);
  endtask

  task automatic test_len_err();
    set_req(0, $urandom, 3, 2'b01);
    serve(1, -1, 0);
    set_req(1, $urandom, 2, 2'b01);
    serve(-1, -1, 0);
    set_req(0, $urandom, 0, 2'b01);
    serve(-1, -1, 0);
  endtask

  initial begin
    ARESET = 1'b1;
    S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0; S_ARVALID = '0;
    S_RREADY = '0; M_ARREADY = 1'b0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0; M_RVALID = 1'b0;
    rand_rdy = 1'b0;
    rr_model = 0;
    len_err_model = 1'b0;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_len_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Round-robin N:1 arbiter that lets NUM_M AXI4 read masters share the single read port (AR/R channels) of one axi_slave.
- Exactly one read transaction is outstanding at a time. A grant is held from AR acceptance through the RLAST handshake, then released.
- Sits between the requesting masters (DMA, CPU bridge, etc.) and the slave's AR/R ports. The write channels bypass this block.

Parameters:
- NUM_M, 2, number of requesting masters (>=2).
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width.
- GW, $clog2(NUM_M), grant index width (derived; do not override).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_ARADDR  in  NUM_M*ADDR_WIDTH  packed per-master addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- S_ARLEN  in  NUM_M*8  packed ARLEN.
- S_ARSIZE  in  NUM_M*3  packed ARSIZE.
- S_ARBURST  in  NUM_M*2  packed ARBURST.
- S_ARVALID  in  NUM_M  per-master ARVALID.
- S_ARREADY  out  NUM_M  per-master ARREADY.
- S_RDATA  out  DATA_WIDTH  RDATA broadcast to all masters.
- S_RRESP  out  2  RRESP broadcast.
- S_RLAST  out  1  RLAST broadcast.
- S_RVALID  out  NUM_M  per-master RVALID; only the granted bit can be 1.
- S_RREADY  in  NUM_M  per-master RREADY.
- M_ARADDR  out  ADDR_WIDTH  to slave.
- M_ARLEN  out  8  to slave.
- M_ARSIZE  out  3  to slave.
- M_ARBURST  out  2  to slave.
- M_ARVALID  out  1  to slave.
- M_ARREADY  in  1  from slave.
- M_RDATA  in  DATA_WIDTH  from slave.
- M_RRESP  in  2  from slave.
- M_RLAST  in  1  from slave.
- M_RVALID  in  1  from slave.
- M_RREADY  out  1  to slave.
- GRANT  out  GW  currently or last granted master index.
- BUSY  out  1  high in ARB_ADDR or ARB_DATA.
- LEN_ERR  out  1  sticky burst-length mismatch flag (see Optional Feature).

Behaviour:

Reset (ARESET high, asynchronous):
- state=ARB_IDLE, rr_ptr=0, GRANT=0, BUSY=0, LEN_ERR=0, beat counter=0.
- All combinational outputs evaluate to 0 in ARB_IDLE: M_ARVALID, M_RREADY, S_ARREADY, S_RVALID.
- Reset mid-transaction abandons it. No R beat is routed after reset.

States:
- ARB_IDLE:
  - If S_ARVALID != 0, pick the first set bit searching from rr_ptr upward, modulo NUM_M.
  - Register GRANT=pick, then go to ARB_ADDR. Arbitration costs exactly 1 cycle.
  - Nothing is forwarded while in ARB_IDLE.
- ARB_ADDR:
  - M_AR* = S_AR*[GRANT] and M_ARVALID = S_ARVALID[GRANT], combinational pass-through.
  - S_ARREADY[GRANT] = M_ARREADY; all other S_ARREADY bits are 0.
  - On M_ARVALID && M_ARREADY: latch beats_exp = ARLEN+1 (9-bit), go to ARB_DATA.
  - If the granted master drops ARVALID (protocol violation), stay in ARB_ADDR. Do not re-arbitrate.
- ARB_DATA:
  - S_RDATA/S_RRESP/S_RLAST = M_R*.
  - S_RVALID[GRANT] = M_RVALID; M_RREADY = S_RREADY[GRANT]. Non-granted S_RVALID bits are 0.
  - Each M_RVALID && M_RREADY increments the beat counter.
  - On a handshake with M_RLAST=1: go to ARB_IDLE, rr_ptr = (GRANT+1) mod NUM_M, clear the beat counter.
  - New requests arriving during ARB_DATA wait. Their S_ARREADY stays 0.
- Outside ARB_DATA, M_RREADY=0 and all S_RVALID=0. Stray slave R beats are never consumed.

Other rules:
- Pass-through paths are combinational. No data or handshake latency is added beyond the 1-cycle arbitration.
- Fairness: a master requesting continuously is granted at least once every NUM_M transactions.
- Simultaneous RLAST handshake and a new request: the new request is arbitrated in the following ARB_IDLE cycle, using the updated rr_ptr.
- An error burst from the slave (RRESP=2'b10) is routed unchanged. Release still waits for RLAST.

Optional Feature:
- Macro AXI_RD_ARB_LEN_CHECK_EN.
- Defined:
  - In ARB_DATA, on each handshake compare beat count (including the current beat) against beats_exp.
  - RLAST before beats_exp, or beats_exp reached without RLAST, sets LEN_ERR=1 (sticky until ARESET).
  - Release still follows M_RLAST.
- Undefined: checker logic is absent and LEN_ERR is tied to 0.

Test Plan:
- Single request: master 0 ARADDR=0x10, ARLEN=3, INCR; slave returns 4 beats → GRANT=0, 4 beats on S_RVALID[0] only, S_RVALID[1]=0 throughout, BUSY falls the cycle after the RLAST handshake.
- Contention: masters 0 and 1 assert ARVALID the same cycle after reset → master 0 served first, then master 1; rr_ptr ends at 0.
- Fairness: both masters request continuously for 6 ARLEN=0 transactions → grant sequence 0,1,0,1,0,1.
- Backpressure: S_RREADY[GRANT] low for 3 cycles mid-burst → M_RREADY low for those cycles, RDATA held, no beat lost, beat count correct.
- Reset mid-burst: ARESET asserted after beat 2 of 4 → outputs 0 immediately; after release, master 1 requests and is granted (rr_ptr=0 search finds 1).
- With AXI_RD_ARB_LEN_CHECK_EN: ARLEN=3 but slave asserts RLAST on beat 2 → LEN_ERR=1, arbiter returns to idle, LEN_ERR stays 1 across later good bursts.
